// File: rtl/music_pkg.sv
// Shared definitions for the note playback blocks: sequencer states, load latency and widths.
package music_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      TONE,
      GAP
   } play_state_t;

   localparam int LOAD_WAIT = 3;
   localparam int AUDIO_W   = 32;
   localparam int SLOT_W    = 4;

endpackage

// File: rtl/square_wave_gen.sv
// Square-wave phase tracker with a zero-rest sample mux; a half period of 0 means silence.
module square_wave_gen
   import music_pkg::*;
#(
   parameter logic [AUDIO_W-1:0] AMPLITUDE = 32'h0800_0000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clear,
   input  logic               enable,
   input  logic [AUDIO_W-1:0] half_period,
   output logic               phase,
   output logic [AUDIO_W-1:0] sample
);

   localparam logic [AUDIO_W-1:0] NEG_LEVEL = ~AMPLITUDE + AUDIO_W'(1);

   logic [AUDIO_W-1:0] phase_cnt;

   // A new note restarts on the high half; the counter only runs for non-rest notes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase_cnt <= '0;
         phase     <= 1'b0;
      end else if (clear) begin
         phase_cnt <= '0;
         phase     <= 1'b1;
      end else if (enable && (half_period != '0)) begin
         if (phase_cnt == half_period - AUDIO_W'(1)) begin
            phase_cnt <= '0;
            phase     <= ~phase;
         end else begin
            phase_cnt <= phase_cnt + AUDIO_W'(1);
         end
      end
   end

   always_comb begin
      sample = '0;
      if (half_period != '0) begin
         sample = phase ? AMPLITUDE : NEG_LEVEL;
      end
   end

endmodule

// File: rtl/note_player.sv
// Playback sequencer: steps through recorded slots and emits a square-wave sample stream.
// Define NOTE_PLAYER_LOOP_EN to repeat the recording instead of ending the pass with done.
module note_player
   import music_pkg::*;
#(
   parameter int unsigned        NOTE_TICKS = 12_500_000,
   parameter int unsigned        GAP_TICKS  = 2_500_000,
   parameter logic [AUDIO_W-1:0] AMPLITUDE  = 32'h0800_0000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               play_en,
   input  logic [SLOT_W-1:0]  notes_recorded,
   input  logic [AUDIO_W-1:0] freq_in,
   input  logic               audio_ready,
   output logic [SLOT_W-1:0]  note_counter,
   output logic               next_note_en,
   output logic [AUDIO_W-1:0] audio_out,
   output logic               audio_write,
   output logic               done
);

   localparam logic [31:0]       LOAD_LAST = 32'(LOAD_WAIT - 1);
   localparam logic [31:0]       NOTE_LAST = 32'(NOTE_TICKS - 1);
   localparam logic [31:0]       GAP_LAST  = 32'(GAP_TICKS - 1);
   localparam logic [SLOT_W-1:0] MAX_COUNT = '1;

   play_state_t        state, state_next;
   logic [31:0]        tick_cnt, tick_next;
   logic [SLOT_W-1:0]  counter_next;
   logic               note_en_next, done_next;
   logic [AUDIO_W-1:0] half_period;
   logic               latch_freq;
   logic               wait_low, wait_low_next;
   logic               more_slots;
   logic               phase_unused;
   logic [AUDIO_W-1:0] tone_sample;

   // The top counter value cannot address a further slot, so it also ends the pass.
   assign more_slots = (note_counter <= notes_recorded) && (note_counter != MAX_COUNT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         tick_cnt     <= '0;
         note_counter <= '0;
         next_note_en <= 1'b0;
         done         <= 1'b0;
         half_period  <= '0;
         wait_low     <= 1'b0;
      end else begin
         state        <= state_next;
         tick_cnt     <= tick_next;
         note_counter <= counter_next;
         next_note_en <= note_en_next;
         done         <= done_next;
         wait_low     <= wait_low_next;
         if (latch_freq) begin
            half_period <= freq_in;
         end
      end
   end

   // wait_low blocks an immediate restart after a completed pass until play_en has dropped.
   always_comb begin
      state_next    = state;
      tick_next     = tick_cnt + 32'd1;
      counter_next  = note_counter;
      note_en_next  = 1'b0;
      done_next     = 1'b0;
      latch_freq    = 1'b0;
      wait_low_next = wait_low && play_en;

      case (state)
         IDLE: begin
            tick_next    = '0;
            counter_next = '0;
            if (play_en && !wait_low) begin
               counter_next = SLOT_W'(1);
               note_en_next = 1'b1;
               state_next   = LOAD;
            end
         end
         LOAD: begin
            if (tick_cnt == LOAD_LAST) begin
               latch_freq = 1'b1;
               tick_next  = '0;
               state_next = TONE;
            end
         end
         TONE: begin
            if (tick_cnt == NOTE_LAST) begin
               tick_next  = '0;
               state_next = GAP;
            end
         end
         GAP: begin
            if (tick_cnt == GAP_LAST) begin
               tick_next = '0;
               if (more_slots) begin
                  counter_next = note_counter + SLOT_W'(1);
                  note_en_next = 1'b1;
                  state_next   = LOAD;
               end else begin
`ifdef NOTE_PLAYER_LOOP_EN
                  counter_next = SLOT_W'(1);
                  note_en_next = 1'b1;
                  state_next   = LOAD;
`else
                  counter_next  = '0;
                  done_next     = 1'b1;
                  wait_low_next = 1'b1;
                  state_next    = IDLE;
`endif
               end
            end
         end
         default: state_next = IDLE;
      endcase

      // Stopping outranks every transition above, including a GAP exit in the same cycle.
      if ((state != IDLE) && !play_en) begin
         state_next    = IDLE;
         tick_next     = '0;
         counter_next  = '0;
         note_en_next  = 1'b0;
         done_next     = 1'b0;
         latch_freq    = 1'b0;
         wait_low_next = 1'b0;
      end
   end

   square_wave_gen #(
      .AMPLITUDE(AMPLITUDE)
   ) u_wave (
      .clk        (clk),
      .reset      (reset),
      .clear      (latch_freq),
      .enable     (state == TONE),
      .half_period(half_period),
      .phase      (phase_unused),
      .sample     (tone_sample)
   );

   assign audio_out   = (state == TONE) ? tone_sample : '0;
   assign audio_write = audio_ready && ((state == TONE) || (state == GAP));

endmodule

// File: tb/tb_note_player.sv
// Bench for note_player: a slot/position model of the playback schedule is checked every
// cycle, alongside directed literal expectations for each scenario.
module tb_note_player;

   localparam int          NOTE   = 20;
   localparam int          GAP    = 4;
   localparam int          PERIOD = 3 + NOTE + GAP;
   localparam logic [31:0] AMP    = 32'h0100_0000;
   localparam logic [31:0] NEG    = 32'hFF00_0000;

   logic        clk            = 1'b0;
   logic        reset          = 1'b1;
   logic        play_en        = 1'b0;
   logic [3:0]  notes_recorded = 4'd0;
   logic [31:0] freq_in;
   logic        audio_ready    = 1'b1;
   logic [3:0]  note_counter;
   logic        next_note_en;
   logic [31:0] audio_out;
   logic        audio_write;
   logic        done;

   logic [31:0] freq_table [16];
   logic [31:0] freq_direct = 32'd0;
   bit          use_table   = 1'b0;
   bit          bp_mode     = 1'b0;
   int          bp_phase    = 0;
   int          cycle       = 0;
   int          n_checks    = 0;
   int          n_errors    = 0;

   // Model of the playback: active pass, slot number k, position within the note period.
   bit          m_active = 1'b0;
   int          m_k      = 0;
   int          m_pos    = 0;
   logic [31:0] m_hp     = 32'd0;
   bit          m_nne    = 1'b0;
   bit          m_done   = 1'b0;
   bit          m_wait   = 1'b0;

   note_player #(
      .NOTE_TICKS(NOTE),
      .GAP_TICKS (GAP),
      .AMPLITUDE (AMP)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .play_en       (play_en),
      .notes_recorded(notes_recorded),
      .freq_in       (freq_in),
      .audio_ready   (audio_ready),
      .note_counter  (note_counter),
      .next_note_en  (next_note_en),
      .audio_out     (audio_out),
      .audio_write   (audio_write),
      .done          (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle++;

   // Stands in for the datapath's slot memory.
   assign freq_in = (use_table && note_counter != 4'd0) ? freq_table[note_counter - 4'd1] : freq_direct;

   always begin
      @(negedge clk);
      #1;
      if (bp_mode) begin
         audio_ready = (bp_phase == 0);
         bp_phase    = (bp_phase + 1) % 4;
      end else begin
         audio_ready = 1'b1;
      end
   end

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_active = 1'b0;
         m_k      = 0;
         m_pos    = 0;
         m_hp     = 32'd0;
         m_nne    = 1'b0;
         m_done   = 1'b0;
         m_wait   = 1'b0;
      end else begin
         m_nne  = 1'b0;
         m_done = 1'b0;
         if (!play_en) m_wait = 1'b0;
         if (m_active) begin
            if (!play_en) begin
               m_active = 1'b0;
               m_k      = 0;
            end else if (m_pos == PERIOD - 1) begin
               m_pos = 0;
               if (m_k <= int'(notes_recorded) && m_k < 15) begin
                  m_k++;
                  m_nne = 1'b1;
               end else begin
`ifdef NOTE_PLAYER_LOOP_EN
                  m_k   = 1;
                  m_nne = 1'b1;
`else
                  m_active = 1'b0;
                  m_k      = 0;
                  m_done   = 1'b1;
                  m_wait   = 1'b1;
`endif
               end
            end else begin
               if (m_pos == 2) m_hp = freq_in;
               m_pos++;
            end
         end else if (play_en && !m_wait) begin
            m_active = 1'b1;
            m_k      = 1;
            m_pos    = 0;
            m_nne    = 1'b1;
         end
      end
   end

   function automatic logic [31:0] model_audio();
      longint i;
      if (!m_active || m_pos < 3 || m_pos >= 3 + NOTE || m_hp == 32'd0) return 32'd0;
      i = longint'(m_pos - 3);
      return ((i / longint'(m_hp)) % 2 == 0) ? AMP : NEG;
   endfunction

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   always @(negedge clk) begin
      check_output("model_note_counter", 32'(note_counter), 32'(m_k));
      check_output("model_next_note_en", 32'(next_note_en), 32'(m_nne));
      check_output("model_done", 32'(done), 32'(m_done));
      check_output("model_audio_out", audio_out, model_audio());
      check_output("model_audio_write", 32'(audio_write),
                   32'(audio_ready && m_active && m_pos >= 3));
   end

   task automatic apply_stimulus(input bit p, input logic [3:0] nr, input logic [31:0] f, input bit tbl);
      #1;
      play_en        = p;
      notes_recorded = nr;
      freq_direct    = f;
      use_table      = tbl;
   endtask

   task automatic wait_pulse(output int at_cycle);
      at_cycle = -1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (next_note_en) begin
            at_cycle = cycle;
            break;
         end
      end
      check_output("pulse_seen", 32'(at_cycle >= 0), 32'd1);
   endtask

   task automatic wait_done();
      bit seen = 1'b0;
      for (int i = 0; i < 120; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      check_output("done_seen", 32'(seen), 32'd1);
   endtask

   initial begin
      int c1, c2, c3, writes, pulses, maxc;
      for (int i = 0; i < 16; i++) freq_table[i] = 32'd2;
      freq_table[0] = 32'd3;
      freq_table[1] = 32'd0;
      freq_table[2] = 32'd1;

      repeat (2) @(negedge clk);
      check_output("reset_note_counter", 32'(note_counter), 32'd0);
      check_output("reset_audio_out", audio_out, 32'd0);
      check_output("reset_audio_write", 32'(audio_write), 32'd0);
      check_output("reset_done", 32'(done), 32'd0);
      #1 reset = 1'b0;

      $display("[TB] single pass, one slot");
      @(negedge clk);
      apply_stimulus(1'b1, 4'd0, 32'd5, 1'b0);
      wait_pulse(c1);
      check_output("t1_counter", 32'(note_counter), 32'd1);
      repeat (3) @(negedge clk);
      check_output("t1_first_tone", audio_out, AMP);
      repeat (4) @(negedge clk);
      check_output("t1_fifth_high", audio_out, AMP);
      @(negedge clk);
      check_output("t1_first_low", audio_out, NEG);
      repeat (15) @(negedge clk);
      check_output("t1_gap", audio_out, 32'd0);
`ifndef NOTE_PLAYER_LOOP_EN
      repeat (4) @(negedge clk);
      check_output("t1_done", 32'(done), 32'd1);
      check_output("t1_idle_counter", 32'(note_counter), 32'd0);
      @(negedge clk);
      check_output("t1_done_once", 32'(done), 32'd0);
`endif
      apply_stimulus(1'b0, 4'd0, 32'd5, 1'b0);
      repeat (2) @(negedge clk);

      $display("[TB] three slots");
      apply_stimulus(1'b1, 4'd2, 32'd0, 1'b1);
      wait_pulse(c1);
      check_output("t2_slot1", 32'(note_counter), 32'd1);
      wait_pulse(c2);
      check_output("t2_spacing12", 32'(c2 - c1), 32'd27);
      check_output("t2_slot2", 32'(note_counter), 32'd2);
      repeat (3) @(negedge clk);
      check_output("t2_rest", audio_out, 32'd0);
      wait_pulse(c3);
      check_output("t2_spacing23", 32'(c3 - c2), 32'd27);
      check_output("t2_slot3", 32'(note_counter), 32'd3);
      repeat (3) @(negedge clk);
      check_output("t2_toggle_hi", audio_out, AMP);
      @(negedge clk);
      check_output("t2_toggle_lo", audio_out, NEG);
      @(negedge clk);
      check_output("t2_toggle_hi2", audio_out, AMP);
`ifndef NOTE_PLAYER_LOOP_EN
      wait_done();
      check_output("t2_end_counter", 32'(note_counter), 32'd0);
`else
      wait_pulse(c1);
      check_output("t2_wrap", 32'(note_counter), 32'd1);
`endif
      apply_stimulus(1'b0, 4'd2, 32'd0, 1'b0);
      repeat (2) @(negedge clk);

      $display("[TB] stop mid-tone");
      apply_stimulus(1'b1, 4'd0, 32'd5, 1'b0);
      wait_pulse(c1);
      repeat (12) @(negedge clk);
      apply_stimulus(1'b0, 4'd0, 32'd5, 1'b0);
      @(negedge clk);
      check_output("t3_counter", 32'(note_counter), 32'd0);
      check_output("t3_audio", audio_out, 32'd0);
      check_output("t3_no_done", 32'(done), 32'd0);
      repeat (2) @(negedge clk);

      $display("[TB] codec backpressure");
      bp_mode = 1'b1;
      @(negedge clk);
      apply_stimulus(1'b1, 4'd0, 32'd7, 1'b0);
      wait_pulse(c1);
      writes = 0;
      for (int i = 0; i < 27; i++) begin
         @(negedge clk);
         if (audio_write) writes++;
      end
      check_output("t4_write_count", 32'(writes), 32'd6);
      apply_stimulus(1'b0, 4'd0, 32'd7, 1'b0);
      bp_mode = 1'b0;
      repeat (2) @(negedge clk);

`ifndef NOTE_PLAYER_LOOP_EN
      $display("[TB] sixteen-slot recording");
      apply_stimulus(1'b1, 4'd15, 32'd0, 1'b1);
      pulses = 0;
      maxc   = 0;
      c1     = 0;
      for (int i = 0; i < 450; i++) begin
         @(negedge clk);
         if (next_note_en) pulses++;
         if (int'(note_counter) > maxc) maxc = int'(note_counter);
         if (done) begin
            c1 = 1;
            break;
         end
      end
      check_output("t5_done_seen", 32'(c1), 32'd1);
      check_output("t5_pulses", 32'(pulses), 32'd15);
      check_output("t5_max_counter", 32'(maxc), 32'd15);
      apply_stimulus(1'b0, 4'd0, 32'd0, 1'b0);
      repeat (2) @(negedge clk);
`else
      $display("[TB] loop build");
      apply_stimulus(1'b1, 4'd1, 32'd4, 1'b0);
      for (int j = 0; j < 4; j++) begin
         wait_pulse(c1);
         check_output("t6_loop_counter", 32'(note_counter), (j % 2 == 0) ? 32'd1 : 32'd2);
      end
      apply_stimulus(1'b0, 4'd0, 32'd0, 1'b0);
      repeat (2) @(negedge clk);
`endif

      $display("[TB] reset mid-tone");
      apply_stimulus(1'b1, 4'd0, 32'd5, 1'b0);
      wait_pulse(c1);
      repeat (5) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check_output("t7_counter", 32'(note_counter), 32'd0);
      check_output("t7_audio", audio_out, 32'd0);
      check_output("t7_write", 32'(audio_write), 32'd0);
      check_output("t7_pulse", 32'(next_note_en), 32'd0);
      check_output("t7_done", 32'(done), 32'd0);
      @(negedge clk);
      apply_stimulus(1'b0, 4'd0, 32'd5, 1'b0);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check_output("t7_idle", 32'(note_counter), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
